// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch T0..T2 plus opcode-dependent execute steps T3..T7.
// Strobes are Moore outputs decoded from the present step and the held instruction.
module control_sequencer #(
    parameter logic [4:0] ADD_SEL = 5'b00011,
    parameter logic [4:0] AND_SEL = 5'b00101,
    parameter logic [4:0] OR_SEL  = 5'b00110
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [31:0] ir,
    input  logic        con_ff,
    input  logic        stop,
    input  logic        start,
    output logic        run,
    output logic        Gra,
    output logic        Grb,
    output logic        Grc,
    output logic        Rin,
    output logic        R_out,
    output logic        BAout,
    output logic        C_out,
    output logic        PC_out,
    output logic        PC_rd,
    output logic        IncPC,
    output logic        MAR_rd,
    output logic        MDR_rd,
    output logic        MDR_out,
    output logic        IR_rd,
    output logic        Y_rd,
    output logic        Zlo_rd,
    output logic        Zlo_out,
    output logic        CON_rd,
    output logic        Read,
    output logic        Write,
    output logic [4:0]  op_sel
);

    typedef enum logic [3:0] {
        S_RESET, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        I_LD, I_LDI, I_ST, I_ALU, I_ADDI, I_ANDI, I_ORI, I_BR, I_JR, I_NOP, I_HALT
    } instr_t;

    state_t     state_q, state_d;
    logic       stop_q, stop_d;
    logic       rst_hold_q, rst_hold_d;
    instr_t     cls;
    state_t     last_step;
    logic [4:0] opcode;
    logic       unused_ir;

    assign opcode    = ir[31:27];
    assign unused_ir = ^ir[26:0];

    always_comb begin
        cls = I_NOP;
        case (opcode)
            5'b00000: cls = I_LD;
            5'b00001: cls = I_LDI;
            5'b00010: cls = I_ST;
            5'b01100: cls = I_ADDI;
            5'b01101: cls = I_ANDI;
            5'b01110: cls = I_ORI;
            5'b10010: cls = I_BR;
            5'b10011: cls = I_JR;
            5'b11011: cls = I_HALT;
            default: begin
                if (opcode >= 5'b00011 && opcode <= 5'b01011) cls = I_ALU;
            end
        endcase
    end

    always_comb begin
        last_step = S_T2;
        case (cls)
            I_LD, I_ST:                    last_step = S_T7;
            I_LDI, I_ALU, I_ADDI, I_ANDI,
            I_ORI:                         last_step = S_T5;
            I_BR:                          last_step = S_T6;
            I_JR:                          last_step = S_T3;
            default:                       last_step = S_T2;
        endcase
    end

    // RESET holds one full clock after clr falls before fetching begins
    always_comb begin
        state_d    = state_q;
        stop_d     = stop_q;
        rst_hold_d = rst_hold_q;
        case (state_q)
            S_RESET: begin
                rst_hold_d = 1'b1;
                stop_d     = 1'b0;
                if (rst_hold_q) state_d = S_T0;
            end
            S_HALT: begin
                stop_d = 1'b0;
                if (start) state_d = S_T0;
            end
            default: begin
                if (state_q == last_step) begin
                    stop_d = 1'b0;
                    if (cls == I_HALT || stop_q || stop) state_d = S_HALT;
                    else                                 state_d = S_T0;
                end else begin
                    stop_d  = stop_q | stop;
                    state_d = state_t'(state_q + 4'd1);
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= S_RESET;
            stop_q     <= 1'b0;
            rst_hold_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            stop_q     <= stop_d;
            rst_hold_q <= rst_hold_d;
        end
    end

    always_comb begin
        run     = (state_q != S_RESET) && (state_q != S_HALT);
        Gra     = 1'b0; Grb    = 1'b0; Grc    = 1'b0; Rin     = 1'b0;
        R_out   = 1'b0; BAout  = 1'b0; C_out  = 1'b0; PC_out  = 1'b0;
        PC_rd   = 1'b0; IncPC  = 1'b0; MAR_rd = 1'b0; MDR_rd  = 1'b0;
        MDR_out = 1'b0; IR_rd  = 1'b0; Y_rd   = 1'b0; Zlo_rd  = 1'b0;
        Zlo_out = 1'b0; CON_rd = 1'b0; Read   = 1'b0; Write   = 1'b0;
        op_sel  = '0;
        case (state_q)
            S_T0: begin PC_out = 1'b1; MAR_rd = 1'b1; IncPC = 1'b1; Zlo_rd = 1'b1; end
            S_T1: begin Zlo_out = 1'b1; PC_rd = 1'b1; Read = 1'b1; MDR_rd = 1'b1; end
            S_T2: begin MDR_out = 1'b1; IR_rd = 1'b1; end
            S_T3: begin
                case (cls)
                    I_LD, I_LDI, I_ST: begin Grb = 1'b1; BAout = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
                    I_ALU, I_ADDI, I_ANDI, I_ORI: begin Grb = 1'b1; R_out = 1'b1; Y_rd = 1'b1; end
                    I_BR: begin Gra = 1'b1; R_out = 1'b1; CON_rd = 1'b1; end
                    I_JR: begin Gra = 1'b1; R_out = 1'b1; PC_rd = 1'b1; end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    I_LD, I_LDI, I_ST: begin C_out = 1'b1; op_sel = ADD_SEL; Zlo_rd = 1'b1; end
                    I_ALU:  begin Grc = 1'b1; R_out = 1'b1; op_sel = opcode; Zlo_rd = 1'b1; end
                    I_ADDI: begin C_out = 1'b1; op_sel = ADD_SEL; Zlo_rd = 1'b1; end
                    I_ANDI: begin C_out = 1'b1; op_sel = AND_SEL; Zlo_rd = 1'b1; end
                    I_ORI:  begin C_out = 1'b1; op_sel = OR_SEL;  Zlo_rd = 1'b1; end
                    I_BR:   begin PC_out = 1'b1; Y_rd = 1'b1; end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    I_LD, I_ST: begin Zlo_out = 1'b1; MAR_rd = 1'b1; end
                    I_LDI, I_ALU, I_ADDI, I_ANDI, I_ORI: begin Zlo_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    I_BR: begin C_out = 1'b1; op_sel = ADD_SEL; Zlo_rd = 1'b1; end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    I_LD: begin Read = 1'b1; MDR_rd = 1'b1; end
                    I_ST: begin Gra = 1'b1; R_out = 1'b1; MDR_rd = 1'b1; end
                    I_BR: begin Zlo_out = con_ff; PC_rd = con_ff; end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    I_LD: begin MDR_out = 1'b1; Gra = 1'b1; Rin = 1'b1; end
                    I_ST: Write = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

endmodule
